// File: rtl/fifo_burst_drain.sv
// Read-side consumer for the synchronous FIFO: issues reads, absorbs the one-cycle read latency
// and re-emits words as a framed valid/ready packet stream (16-word bursts or 1-word flushes).
module fifo_burst_drain #(
  parameter int WORD_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_empty,
  input  logic                  i_aempty,
  output logic                  o_r_en,
  input  logic [WORD_WIDTH-1:0] i_r_data,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_sop,
  output logic                  o_eop,
  output logic                  o_busy
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] BURST_FULL = CW'(BURST_LEN);
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST_LEN - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_SINGLE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [TW-1:0]         timer_q, timer_d;

  // Tags of the read issued last cycle; its data arrives on i_r_data this cycle.
  logic                  inflight_q, inflight_sop_q, inflight_eop_q;

  logic [WORD_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_sop_q, buf_eop_q;
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            occ_q, occ_d;

  logic                  push, pop, rd_allowed, rd_sop, rd_eop;
  logic [2:0]            pending;

  assign o_valid = (occ_q != 2'd0);
  assign pop     = o_valid && i_ready;
  assign push    = inflight_q;

  // Words already committed to the buffer after this cycle's pop; a new read needs a free slot.
  assign pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_allowed = ((state_q == ST_BURST) && (issued_q < BURST_FULL)) ||
                      ((state_q == ST_SINGLE) && (issued_q == '0));
  assign o_r_en     = rd_allowed && !i_empty && (pending < 3'd2);

  assign rd_sop = (issued_q == '0);
  assign rd_eop = (state_q == ST_SINGLE) || ((state_q == ST_BURST) && (issued_q == BURST_LAST));

  assign o_data = buf_data_q[rd_ptr_q];
  assign o_sop  = o_valid && buf_sop_q[rd_ptr_q];
  assign o_eop  = o_valid && buf_eop_q[rd_ptr_q];
  assign o_busy = (state_q != ST_IDLE) || inflight_q || o_valid;

  // NOTE: every variable gets a default at the top of a combinational block so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    timer_d  = timer_q;

    if (o_r_en) issued_d = issued_q + 1'b1;

    // The timer survives SINGLE so leftovers keep draining one word per packet.
    if (i_empty) begin
      timer_d = '0;
    end else if ((state_q == ST_IDLE) && i_aempty && (timer_q != TIMER_MAX)) begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!i_aempty) begin
          state_d  = ST_BURST;
          issued_d = '0;
          timer_d  = '0;
        end else if ((timer_q == TIMER_MAX) && !i_empty) begin
          state_d  = ST_SINGLE;
          issued_d = '0;
        end
      end
      ST_BURST: begin
        if ((issued_q == BURST_FULL) && pop && o_eop) state_d = ST_IDLE;
      end
      ST_SINGLE: begin
        if (pop && o_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (pop && !push) occ_d = occ_q - 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      issued_q       <= '0;
      timer_q        <= '0;
      inflight_q     <= 1'b0;
      inflight_sop_q <= 1'b0;
      inflight_eop_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      issued_q       <= issued_d;
      timer_q        <= timer_d;
      inflight_q     <= o_r_en;
      inflight_sop_q <= rd_sop;
      inflight_eop_q <= rd_eop;
    end
  end

  // NOTE: the two buffer entries are reset so o_data reads 0 out of reset and no stale word can resurface.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_sop_q     <= '0;
      buf_eop_q     <= '0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      occ_q         <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_ptr_q] <= i_r_data;
        buf_sop_q[wr_ptr_q]  <= inflight_sop_q;
        buf_eop_q[wr_ptr_q]  <= inflight_eop_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: a queue-based FIFO model feeds the DUT; a monitor checks stream
// order, framing, stall hold and read accounting every cycle; directed tests pin timing.
module tb_fifo_burst_drain;

  localparam int W     = 8;
  localparam int BL    = 16;
  localparam int TO    = 4;
  localparam int LEVEL = BL - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_empty, i_aempty, i_ready;
  logic [W-1:0] i_r_data;
  logic         o_r_en, o_valid, o_sop, o_eop, o_busy;
  logic [W-1:0] o_data;

  always #5 clk = ~clk;

  fifo_burst_drain #(.WORD_WIDTH(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_empty  (i_empty),
    .i_aempty (i_aempty),
    .o_r_en   (o_r_en),
    .i_r_data (i_r_data),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sop    (o_sop),
    .o_eop    (o_eop),
    .o_busy   (o_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met", name);
  endtask

  // FIFO model and expected stream (every word written, in write order)
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           pend_wr   = 0;
  bit           hide      = 0;
  bit           pend_hide = 0;
  int           rdy_mode  = 0;   // 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never
  int           pat_idx   = 0;

  // Monitor statistics
  int           ren_cnt, acc_cnt, pos, n_burst, n_single, streak, max_streak;
  bit           prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_sop, prev_eop;

  // One clock: sample read enable, model FIFO registered read, apply writes/flags/ready after the edge.
  task automatic tick();
    bit           rd;
    logic [W-1:0] w;
    rd = o_r_en;
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) i_r_data = fq.pop_front();
    for (int i = 0; i < pend_wr; i++) begin
      w = W'($urandom);
      fq.push_back(w);
      exp_q.push_back(w);
    end
    pend_wr  = 0;
    hide     = pend_hide;
    i_empty  = hide || (fq.size() == 0);
    i_aempty = hide || (fq.size() <= LEVEL);
    case (rdy_mode)
      0: i_ready = 1'b1;
      1: begin
        i_ready = (pat_idx == 0) || (pat_idx == 3);
        pat_idx = (pat_idx + 1) % 4;
      end
      2: i_ready = 1'($urandom_range(0, 1));
      default: i_ready = 1'b0;
    endcase
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    ren_cnt    = 0;
    acc_cnt    = 0;
    n_burst    = 0;
    n_single   = 0;
    max_streak = 0;
  endtask

  task automatic drain();
    int k;
    rdy_mode = 0;
    k = 0;
    while ((fq.size() != 0 || o_busy) && k < 5000) begin
      tick();
      k++;
    end
    if (k >= 5000) fail("drain_timeout");
    check("drain_exp_empty", exp_q.size(), 0);
    check("drain_reads_eq_words", ren_cnt, acc_cnt);
  endtask

  task automatic wait_ren(output int k);
    k = 0;
    while (!o_r_en && k < 40) begin
      tick();
      k++;
    end
  endtask

  // Compare process: stream order, framing, stall hold, outstanding-read bound.
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      ren_cnt    = 0;
      acc_cnt    = 0;
      pos        = 0;
      streak     = 0;
      prev_stall = 0;
    end else begin
      check("outstanding_le2", 32'((ren_cnt - acc_cnt) <= 2), 1);
      if (o_r_en) begin
        check("ren_while_empty", i_empty, 0);
        ren_cnt++;
      end
      if (o_valid) begin
        check("busy_when_valid", o_busy, 1);
        streak++;
        if (streak > max_streak) max_streak = streak;
      end else begin
        streak = 0;
      end
      if (prev_stall) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, prev_data);
        check("hold_sop", o_sop, prev_sop);
        check("hold_eop", o_eop, prev_eop);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else check("data_order", o_data, exp_q.pop_front());
        check("sop", o_sop, 32'(pos == 0));
        if (pos == 0 && o_eop) begin
          n_single++;
        end else begin
          check("eop", o_eop, 32'(pos == BL - 1));
          if (pos == BL - 1) begin
            n_burst++;
            pos = 0;
          end else begin
            pos++;
          end
        end
        acc_cnt++;
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_sop   = o_sop;
      prev_eop   = o_eop;
    end
  end

  initial begin
    int k;
    reset_n  = 1'b0;
    i_empty  = 1'b1;
    i_aempty = 1'b1;
    i_ready  = 1'b0;
    i_r_data = '0;
    clear_stats();
    #3;
    check("rst_r_en", o_r_en, 0);
    check("rst_valid", o_valid, 0);
    check("rst_sop", o_sop, 0);
    check("rst_eop", o_eop, 0);
    check("rst_busy", o_busy, 0);
    check("rst_data", o_data, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) tick();

    // Full bursts: latency, framing, back-to-back bursts, leftovers flushed as singles
    clear_stats();
    pend_wr = 40;
    tick();
    wait_ren(k);
    check("t2_ren_delay", k, 1);
    check("t2_valid_at_ren", o_valid, 0);
    tick();
    check("t2_valid_ren_plus1", o_valid, 0);
    tick();
    check("t2_valid_ren_plus2", o_valid, 1);
    check("t2_sop_first", o_sop, 1);
    drain();
    check("t2_bursts", n_burst, 2);
    check("t2_singles", n_single, 8);
    check("t2_words", acc_cnt, 40);
    check("t2_streak", max_streak, BL);

    // Ready pattern 1,0,0,1
    clear_stats();
    rdy_mode = 1;
    pat_idx  = 0;
    pend_wr  = 40;
    tick();
    repeat (60) tick();
    drain();
    check("t3_bursts", n_burst, 2);
    check("t3_singles", n_single, 8);
    check("t3_words", acc_cnt, 40);

    // Timeout flush of three leftover words
    clear_stats();
    pend_wr = 3;
    tick();
    wait_ren(k);
    check("t4_timeout_delay", k, TO + 1);
    drain();
    check("t4_singles", n_single, 3);
    check("t4_bursts", n_burst, 0);
    check("t4_idle_busy", o_busy, 0);

    // Sink stalled at burst start: only two reads may be outstanding
    clear_stats();
    rdy_mode = 3;
    pend_wr  = 20;
    tick();
    repeat (20) tick();
    check("t5_ren_pulses", ren_cnt, 2);
    check("t5_ren_low", o_r_en, 0);
    check("t5_valid_held", o_valid, 1);
    drain();
    check("t5_words", acc_cnt, 20);
    check("t5_bursts", n_burst, 1);
    check("t5_singles", n_single, 4);

    // Empty pulse while timer is at 3 restarts the timeout
    clear_stats();
    pend_wr = 1;
    tick();
    tick();
    tick();
    pend_hide = 1;
    tick();
    check("t6_no_read_hidden", o_r_en, 0);
    pend_hide = 0;
    tick();
    wait_ren(k);
    check("t6_restart_delay", k, TO + 1);
    drain();
    check("t6_singles", n_single, 1);

    // Reset mid-burst with the buffer full
    clear_stats();
    pend_wr = 30;
    tick();
    k = 0;
    while (acc_cnt < 5 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) fail("t1_burst_start_timeout");
    rdy_mode = 3;
    repeat (3) tick();
    check("t1_pre_valid", o_valid, 1);
    check("t1_pre_busy", o_busy, 1);
    reset_n = 1'b0;
    #1;
    check("t1_async_r_en", o_r_en, 0);
    check("t1_async_valid", o_valid, 0);
    check("t1_async_sop", o_sop, 0);
    check("t1_async_eop", o_eop, 0);
    check("t1_async_busy", o_busy, 0);
    check("t1_async_data", o_data, 0);
    fq.delete();
    i_empty  = 1'b1;
    i_aempty = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    reset_n  = 1'b1;
    rdy_mode = 0;
    repeat (5) tick();
    check("t1_post_busy", o_busy, 0);
    check("t1_post_valid", o_valid, 0);
    check("t1_no_burst_done", n_burst, 0);
    pend_wr = 20;
    tick();
    drain();
    check("t1_recover_words", acc_cnt, 20);
    check("t1_recover_bursts", n_burst, 1);

    // Randomized traffic and backpressure
    clear_stats();
    rdy_mode = 2;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) pend_wr = $urandom_range(1, 16);
      tick();
    end
    drain();
    check("rand_idle_busy", o_busy, 0);
    check("rand_no_partial", pos, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
